// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave round-robin arbiter for the bexkat1 shared
// memory bus. Master 0 is the instruction fetch port and master 1 is the
// memory-stage data port. The owner keeps the grant for its whole cycle, and a
// watchdog aborts any bus cycle that never acknowledges.
module bus_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_dat_i,

    input  logic        m1_cyc,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_dat_i,

    output logic        s_cyc,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel,
    input  logic        s_ack,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2,
        S_ABORT  = 2'd3
    } state_e;

    // A zero TIMEOUT still needs a one-bit counter so the declaration stays legal.
    localparam int WdW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic WdEnable = (TIMEOUT > 0);

    state_e         state_q, state_d;
    logic           lastOwner_q, lastOwner_d;
    logic [WdW-1:0] wdCnt_q, wdCnt_d;

    logic inGrant;
    logic ownerIdx;
    logic ownerCyc;
    logic abortOwnerCyc;
    logic wdHit;

    assign inGrant       = (state_q == S_GRANT0) || (state_q == S_GRANT1);
    assign ownerIdx      = (state_q == S_GRANT1);
    assign ownerCyc      = ownerIdx ? m1_cyc : m0_cyc;
    assign abortOwnerCyc = lastOwner_q ? m1_cyc : m0_cyc;
    // An ack in the threshold cycle wins, so the timeout needs s_ack low.
    assign wdHit         = WdEnable && inGrant && !s_ack && (wdCnt_q == WdLast);

    // Read data goes to both masters; only the ack tells the owner it is valid.
    assign m0_dat_i = s_dat_i;
    assign m1_dat_i = s_dat_i;

    // State register with synchronous active-low reset; master 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            lastOwner_q <= 1'b1;
            wdCnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            wdCnt_q     <= wdCnt_d;
        end
    end

    // Next-state logic: round-robin on ties, hold until cyc drops, watchdog abort.
    always_comb begin
        state_d     = state_q;
        lastOwner_d = lastOwner_q;
        wdCnt_d     = wdCnt_q;
        case (state_q)
            S_IDLE: begin
                wdCnt_d = '0;
                if (m0_cyc && m1_cyc) begin
                    state_d = lastOwner_q ? S_GRANT0 : S_GRANT1;
                end else if (m0_cyc) begin
                    state_d = S_GRANT0;
                end else if (m1_cyc) begin
                    state_d = S_GRANT1;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (wdHit) begin
                    state_d     = S_ABORT;
                    lastOwner_d = ownerIdx;
                    wdCnt_d     = '0;
                end else if (!ownerCyc) begin
                    state_d     = S_IDLE;
                    lastOwner_d = ownerIdx;
                    wdCnt_d     = '0;
                end else if (s_ack) begin
                    wdCnt_d = '0;
                end else if (WdEnable) begin
                    wdCnt_d = wdCnt_q + WdW'(1);
                end
            end
            S_ABORT: begin
                wdCnt_d = '0;
                if (!abortOwnerCyc) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wdCnt_d = '0;
            end
        endcase
    end

    // Output mux: the owner's request reaches the slave, and only the owner sees ack/err.
    always_comb begin
        s_cyc   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        s_sel   = '0;
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_err  = 1'b0;
        grant_o = 2'b00;
        case (state_q)
            S_GRANT0: begin
                s_cyc   = m0_cyc;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_o = m0_dat_o;
                s_sel   = m0_sel;
                m0_ack  = s_ack;
                m0_err  = wdHit;
                grant_o = 2'b01;
            end
            S_GRANT1: begin
                s_cyc   = m1_cyc;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_o = m1_dat_o;
                s_sel   = m1_sel;
                m1_ack  = s_ack;
                m1_err  = wdHit;
                grant_o = 2'b10;
            end
            default: begin
                grant_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of the two-master arbiter with TIMEOUT=4.
module tb_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc, m0_we, m1_cyc, m1_we;
    logic [31:0] m0_adr, m0_dat_o, m1_adr, m1_dat_o;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_dat_i, m1_dat_i;
    logic        s_cyc, s_we, s_ack;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic [3:0]  s_sel;
    logic [1:0]  grant_o;

    int vectorCount = 0;
    int missCount   = 0;

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc(m0_cyc), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_o(m0_dat_o),
        .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_i(m0_dat_i),
        .m1_cyc(m1_cyc), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_o(m1_dat_o),
        .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_i(m1_dat_i),
        .s_cyc(s_cyc), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
        .s_sel(s_sel), .s_ack(s_ack), .s_dat_i(s_dat_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance past a rising edge; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive the cyc/ack handshake inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic c0, input logic c1, input logic ack);
        m0_cyc = c0;
        m1_cyc = c1;
        s_ack  = ack;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_i    = 1'b0;
        m0_cyc   = 1'b0; m0_we = 1'b0; m0_adr = 32'h1000; m0_dat_o = 32'h0; m0_sel = 4'hF;
        m1_cyc   = 1'b0; m1_we = 1'b0; m1_adr = 32'h2002; m1_dat_o = 32'h0; m1_sel = 4'hF;
        s_ack    = 1'b0;
        s_dat_i  = 32'h1234_5678;

        // Reset state: everything idle, read data broadcast, stray ack ignored.
        tick(); tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_grant", 32'(grant_o), 32'h0);
        checkOutput("rst_s_cyc", 32'(s_cyc), 32'h0);
        checkOutput("rst_m0_ack", 32'(m0_ack), 32'h0);
        checkOutput("rst_m0_err", 32'(m0_err), 32'h0);
        checkOutput("rst_m0_dat_i", m0_dat_i, 32'h1234_5678);
        checkOutput("rst_m1_dat_i", m1_dat_i, 32'h1234_5678);
        checkOutput("rst_s_adr", s_adr, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        tick();

        // Single fetch from master 0.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("fetch_pre_s_cyc", 32'(s_cyc), 32'h0);
        tick();
        checkOutput("fetch_s_cyc", 32'(s_cyc), 32'h1);
        checkOutput("fetch_s_adr", s_adr, 32'h1000);
        checkOutput("fetch_grant", 32'(grant_o), 32'h1);
        checkOutput("fetch_no_ack_yet", 32'(m0_ack), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("fetch_m0_ack", 32'(m0_ack), 32'h1);
        checkOutput("fetch_m1_ack", 32'(m1_ack), 32'h0);
        checkOutput("fetch_m0_err", 32'(m0_err), 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("fetch_drop_s_cyc", 32'(s_cyc), 32'h0);
        tick();
        checkOutput("fetch_idle_grant", 32'(grant_o), 32'h0);

        // Fresh reset, then four back-to-back ties alternate 0,1,0,1.
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("tie%0d_grant", i), 32'(grant_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput($sformatf("tie%0d_s_adr", i), s_adr, (i % 2 == 0) ? 32'h1000 : 32'h2002);
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput($sformatf("tie%0d_m0_ack", i), 32'(m0_ack), (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("tie%0d_m1_ack", i), 32'(m1_ack), (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            applyStimulus((i % 2 == 0) ? 1'b0 : 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            tick();
            checkOutput($sformatf("tie%0d_gap_grant", i), 32'(grant_o), 32'h0);
            checkOutput($sformatf("tie%0d_gap_s_cyc", i), 32'(s_cyc), 32'h0);
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        // Write from master 1 while master 0 waits.
        m1_we = 1'b1; m1_adr = 32'h2002; m1_sel = 4'b0011; m1_dat_o = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("wr_grant", 32'(grant_o), 32'h2);
        checkOutput("wr_s_we", 32'(s_we), 32'h1);
        checkOutput("wr_s_adr", s_adr, 32'h2002);
        checkOutput("wr_s_sel", 32'(s_sel), 32'h3);
        checkOutput("wr_s_dat_o", s_dat_o, 32'hDEAD_BEEF);
        tick();
        checkOutput("wr_hold_grant", 32'(grant_o), 32'h2);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("wr_m1_ack", 32'(m1_ack), 32'h1);
        checkOutput("wr_m0_ack", 32'(m0_ack), 32'h0);
        tick();
        m1_we = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("wr_gap_grant", 32'(grant_o), 32'h0);
        tick();
        checkOutput("wr_m0_grant", 32'(grant_o), 32'h1);
        checkOutput("wr_m0_s_we", 32'(s_we), 32'h0);
        checkOutput("wr_m0_s_adr", s_adr, 32'h1000);

        // Watchdog: master 0 never acked, master 1 pending.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("wd_cycle%0d_s_cyc", c), 32'(s_cyc), 32'h1);
            checkOutput($sformatf("wd_cycle%0d_m0_err", c), 32'(m0_err), (c == 4) ? 32'h1 : 32'h0);
            if (c < 4) tick();
        end
        checkOutput("wd_m1_err", 32'(m1_err), 32'h0);
        tick();
        checkOutput("abort_s_cyc", 32'(s_cyc), 32'h0);
        checkOutput("abort_grant", 32'(grant_o), 32'h0);
        checkOutput("abort_m0_err", 32'(m0_err), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("abort_hold_grant", 32'(grant_o), 32'h0);
        checkOutput("abort_m0_ack", 32'(m0_ack), 32'h0);
        checkOutput("abort_m1_ack", 32'(m1_ack), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("abort_exit_grant", 32'(grant_o), 32'h0);
        tick();
        checkOutput("abort_m1_grant", 32'(grant_o), 32'h2);

        // Reset while master 1 owns the bus with an ack pending.
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("midrst_grant", 32'(grant_o), 32'h0);
        checkOutput("midrst_s_cyc", 32'(s_cyc), 32'h0);
        checkOutput("midrst_m1_ack", 32'(m1_ack), 32'h0);
        checkOutput("midrst_m1_err", 32'(m1_err), 32'h0);
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("midrst_tie_grant", 32'(grant_o), 32'h1);

        // Ack in the same cycle as the watchdog threshold.
        tick(); tick(); tick();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("coll_m0_ack", 32'(m0_ack), 32'h1);
        checkOutput("coll_m0_err", 32'(m0_err), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("coll_hold_grant", 32'(grant_o), 32'h1);
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("coll_restart%0d_m0_err", c), 32'(m0_err), (c == 4) ? 32'h1 : 32'h0);
            if (c < 4) tick();
        end
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("final_grant", 32'(grant_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the bexkat1 pipelined core's shared memory bus: master 0 is the instruction fetch port, master 1 is the memory-stage data port. Each master drives a cyc/we/adr/dat/sel request and waits for ack. The arbiter grants the single slave bus round-robin, holds the grant for the owner's whole cycle, and muxes the owner's signals onto the slave. A watchdog aborts a bus cycle that never acks.

## Interface
- TIMEOUT, 256: cycles without s_ack before abort. 0 disables the watchdog.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset. Synchronous, active-low: sampled low at a rising clk_i edge resets the block.
- m0_cyc, m1_cyc  in  1  master request / cycle hold.
- m0_we, m1_we  in  1  write enable.
- m0_adr, m1_adr  in  32  byte address.
- m0_dat_o, m1_dat_o  in  32  write data.
- m0_sel, m1_sel  in  4  byte lanes.
- m0_ack, m1_ack  out  1  routed s_ack. Only the owner sees it.
- m0_err, m1_err  out  1  one-cycle timeout-abort pulse to the owner.
- m0_dat_i, m1_dat_i  out  32  s_dat_i broadcast to both masters.
- s_cyc, s_we  out  1  slave cycle / write.
- s_adr  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_sel  out  4  slave byte lanes.
- s_ack  in  1  slave acknowledge.
- s_dat_i  in  32  slave read data.
- grant_o  out  2  one-hot current owner. 00 when no master owns the bus.

## Operation
- State machine: S_IDLE, S_GRANT0, S_GRANT1, S_ABORT.
- Registered state also includes last_owner (1 bit) and wd_cnt, which is clog2(TIMEOUT+1) bits wide.
- Reset values:
  - state = S_IDLE, last_owner = 1 (so master 0 wins the first tie), wd_cnt = 0.
  - All outputs are derived from state, so after reset every output is 0 except m*_dat_i, which follows s_dat_i.
- S_IDLE transitions:
  - Only m0_cyc high: go to S_GRANT0.
  - Only m1_cyc high: go to S_GRANT1.
  - Both high: grant the master that is not last_owner.
  - Neither high: stay in S_IDLE.
- S_GRANTn:
  - s_cyc = mn_cyc. s_we, s_adr, s_dat_o and s_sel come from master n.
  - mn_ack = s_ack. The other master's ack is 0.
  - grant_o[n] = 1.
- In S_IDLE and S_ABORT: s_cyc = s_we = 0, s_adr = s_dat_o = 0, s_sel = 0.
- Leaving S_GRANTn:
  - mn_cyc low at a clock edge: go to S_IDLE and set last_owner = n.
  - The grant is held across multiple acks for as long as mn_cyc stays high. There is no preemption.
- Watchdog, active only in S_GRANTn:
  - Increment wd_cnt each cycle that s_cyc=1 and s_ack=0.
  - Clear wd_cnt on s_ack, and on any state change.
  - When wd_cnt == TIMEOUT-1 and s_ack=0:
    - assert mn_err for that cycle;
    - next state is S_ABORT, with last_owner = n and wd_cnt = 0.
- S_ABORT:
  - Slave is idle (s_cyc = 0).
  - Remain until the aborted owner drops its cyc, then go to S_IDLE.
  - The other master's request waits.
- s_ack arriving while in S_IDLE or S_ABORT is ignored: no master ack.

## Timing
- Arbitration latency:
  - A request first seen high at edge k enters S_GRANT at edge k.
  - s_cyc is high in the cycle after edge k.
  - Minimum 1 cycle from request to s_cyc.
- Ack path is combinational s_ack -> mn_ack, same cycle. No added latency on the data path.
- Turnaround: the owner drops cyc, the arbiter spends one cycle in S_IDLE, and the next grant takes effect the following cycle. This gives a 1-cycle bus gap between owners.
- Simultaneous events:
  - s_ack in the same cycle as the watchdog threshold: the ack wins, no err, and wd_cnt clears.
  - Owner drops cyc in the same cycle as the threshold: err still pulses, then S_ABORT exits to S_IDLE on the next edge.
- Reset mid-cycle: a rst_i-low edge forces S_IDLE regardless of state. s_cyc and grant_o are 0 in the following cycle, and no ack or err is produced.
- Combinational outputs depend only on registered state plus current master and slave inputs. There is no combinational path from s_ack to s_cyc.

## Test plan
- Reset then single fetch: m0_cyc=1, adr=0x1000, s_ack after 2 cycles, then m0_cyc=0.
  - Required: s_cyc high 1 cycle after the request, s_adr=0x1000, m0_ack pulses, m1_ack stays 0, grant_o=01.
- Tie after reset: m0_cyc and m1_cyc rise together.
  - Required: master 0 granted first (grant_o=01).
  - After m0 drops, 1 idle cycle, then grant_o=10. Ties then alternate 0, 1, 0, 1 over 4 transactions.
- Write from master 1: m1_we=1, adr=0x2002, sel=0011, dat=0xDEADBEEF.
  - Required: the slave sees exactly these values while m0 is held off. m0_cyc held high is granted only after m1 releases.
- Watchdog with TIMEOUT=4: the owner never receives s_ack.
  - Required: m0_err pulses on the 4th s_cyc cycle, s_cyc drops the next cycle, and the block stays in S_ABORT until m0_cyc=0.
  - A pending m1 request is granted afterwards.
- Reset mid-transaction: assert rst_i=0 during S_GRANT1 with s_ack pending.
  - Required: grant_o=00 and s_cyc=0 the next cycle, no m1_ack.
  - After release, a new tie grants master 0.
- Ack/timeout collision with TIMEOUT=4: s_ack arrives on the 4th cycle.
  - Required: m0_ack=1, m0_err=0, the grant is retained, and wd_cnt restarts from 0.
